// File: rtl/regs_pin_readback.sv
// rtl/regs_pin_readback.sv - pin level readback with sync, debounce, sticky change flags and irq
module regs_pin_readback #(
   parameter int unsigned DEB_CYCLES = 4,
   parameter logic [15:0] IRQ_MASK   = 16'hFFFF
) (
   input  logic        CLK,
   input  logic        CLR,
   input  logic [15:0] pin_in,
   input  logic [3:0]  rd_sel,
   output logic [7:0]  data_out,
   output logic        rd_valid,
   output logic        irq
);

   // Debounce update fires when the counter already holds DEB_CYCLES-1 and
   // the sample still disagrees, so exactly DEB_CYCLES disagreeing samples
   // are needed before the level moves.
   localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

   logic [15:0] s1_q, s1_d;
   logic [15:0] s2_q, s2_d;
   logic [15:0] lvl_q, lvl_d;
   logic [15:0] chg_q, chg_d;
   logic [7:0]  cnt_q [16];
   logic [7:0]  cnt_d [16];
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        irq_q, irq_d;

   logic [15:0] chg_set;
   logic [15:0] chg_clr;

   // Two-flop synchroniser on every port line.
   always_comb begin
      s1_d = pin_in;
      s2_d = s1_q;
   end

   // Per-line debounce: count disagreeing samples, commit the new level after
   // DEB_CYCLES of them and flag the change; any agreeing sample restarts.
   always_comb begin
      lvl_d   = lvl_q;
      chg_set = '0;
      for (int i = 0; i < 16; i++) begin
         cnt_d[i] = cnt_q[i];
         if (s2_q[i] == lvl_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == DEB_LAST) begin
            lvl_d[i]   = s2_q[i];
            cnt_d[i]   = '0;
            chg_set[i] = 1'b1;
         end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
         end
      end
   end

   // Read mux with lowest-index priority; a change-byte read clears only
   // that byte, and a flag set in the same cycle survives the clear.
   always_comb begin
      data_d  = data_q;
      valid_d = 1'b0;
      chg_clr = '0;
      if (rd_sel[0]) begin
         data_d  = lvl_q[7:0];
         valid_d = 1'b1;
      end else if (rd_sel[1]) begin
         data_d  = lvl_q[15:8];
         valid_d = 1'b1;
      end else if (rd_sel[2]) begin
         data_d       = chg_q[7:0];
         valid_d      = 1'b1;
         chg_clr[7:0] = 8'hFF;
      end else if (rd_sel[3]) begin
         data_d        = chg_q[15:8];
         valid_d       = 1'b1;
         chg_clr[15:8] = 8'hFF;
      end
      chg_d = (chg_q & ~chg_clr) | chg_set;
      irq_d = |(chg_d & IRQ_MASK);
   end

   // State registers with synchronous clear.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         s1_q    <= '0;
         s2_q    <= '0;
         lvl_q   <= '0;
         chg_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         irq_q   <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         lvl_q   <= lvl_d;
         chg_q   <= chg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         irq_q   <= irq_d;
         for (int i = 0; i < 16; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign data_out = data_q;
   assign rd_valid = valid_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_regs_pin_readback.sv
// tb/tb_regs_pin_readback.sv - table-driven bench for regs_pin_readback
module tb_regs_pin_readback;

   logic        CLK;
   logic        CLR;
   logic [15:0] pin_in;
   logic [3:0]  rd_sel;
   logic [7:0]  data_out;
   logic        rd_valid;
   logic        irq;

   int checks;
   int errors;

   typedef struct {
      logic        clr;
      logic [15:0] pin;
      logic [3:0]  sel;
      logic [7:0]  d;
      logic        v;
      logic        i;
   } vec_t;

   vec_t tbl[$];

   regs_pin_readback #(.DEB_CYCLES(4), .IRQ_MASK(16'hFFFF)) dut (
      .CLK      (CLK),
      .CLR      (CLR),
      .pin_in   (pin_in),
      .rd_sel   (rd_sel),
      .data_out (data_out),
      .rd_valid (rd_valid),
      .irq      (irq)
   );

   // Free-running clock.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic add(input logic clr, input logic [15:0] pin, input logic [3:0] sel,
                      input logic [7:0] d, input logic v, input logic i);
      vec_t e;
      e.clr = clr; e.pin = pin; e.sel = sel; e.d = d; e.v = v; e.i = i;
      tbl.push_back(e);
   endtask

   task automatic add_n(input int n, input logic [15:0] pin, input logic [3:0] sel,
                        input logic [7:0] d, input logic v, input logic i);
      for (int k = 0; k < n; k++) add(1'b0, pin, sel, d, v, i);
   endtask

   task automatic check(input string name, input int idx, input logic [15:0] act,
                        input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d actual %h required %h", name, idx, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int n;
      checks = 0;
      errors = 0;
      CLR    = 1'b1;
      pin_in = 16'hFFFF;
      rd_sel = 4'b0000;

      // Reset with pins high and a read strobe during reset.
      add(1'b1, 16'hFFFF, 4'b0000, 8'h00, 1'b0, 1'b0);
      add(1'b1, 16'hFFFF, 4'b0010, 8'h00, 1'b0, 1'b0);
      // Change flags empty after reset.
      add_n(1, 16'h0000, 4'b0100, 8'h00, 1'b1, 1'b0);
      add_n(1, 16'h0000, 4'b1000, 8'h00, 1'b1, 1'b0);
      // Clean step on bit 0 while reading level continuously.
      add_n(5, 16'h0001, 4'b0001, 8'h00, 1'b1, 1'b0);
      add_n(1, 16'h0001, 4'b0001, 8'h00, 1'b1, 1'b1);
      add_n(1, 16'h0001, 4'b0001, 8'h01, 1'b1, 1'b1);
      add_n(1, 16'h0001, 4'b0000, 8'h01, 1'b0, 1'b1);
      // Three-sample glitch on bit 3 must not move the level.
      add_n(3, 16'h0009, 4'b0000, 8'h01, 1'b0, 1'b1);
      add_n(4, 16'h0001, 4'b0000, 8'h01, 1'b0, 1'b1);
      add_n(1, 16'h0001, 4'b0001, 8'h01, 1'b1, 1'b1);
      // Bit 15 rises, then clear-on-read of each change byte.
      add_n(6, 16'h8001, 4'b0000, 8'h01, 1'b0, 1'b1);
      add_n(1, 16'h8001, 4'b0010, 8'h80, 1'b1, 1'b1);
      add_n(1, 16'h8001, 4'b0100, 8'h01, 1'b1, 1'b1);
      add_n(1, 16'h8001, 4'b1000, 8'h80, 1'b1, 1'b0);
      add_n(1, 16'h8001, 4'b0000, 8'h80, 1'b0, 1'b0);
      add_n(1, 16'h8001, 4'b0100, 8'h00, 1'b1, 1'b0);
      // Bit 1 debounce completes on the same edge as a clearing read.
      add_n(5, 16'h8003, 4'b0000, 8'h00, 1'b0, 1'b0);
      add_n(1, 16'h8003, 4'b0100, 8'h00, 1'b1, 1'b1);
      add_n(1, 16'h8003, 4'b0100, 8'h02, 1'b1, 1'b0);
      // Eight lines toggle, giving chg = 16'h0F0F; then multi-select reads.
      add_n(5, 16'h8F0C, 4'b0000, 8'h02, 1'b0, 1'b0);
      add_n(1, 16'h8F0C, 4'b0000, 8'h02, 1'b0, 1'b1);
      add_n(1, 16'h8F0C, 4'b1100, 8'h0F, 1'b1, 1'b1);
      add_n(1, 16'h8F0C, 4'b1000, 8'h0F, 1'b1, 1'b0);
      add_n(1, 16'h8F0C, 4'b0100, 8'h00, 1'b1, 1'b0);
      add_n(1, 16'h8F0C, 4'b0011, 8'h0C, 1'b1, 1'b0);
      add_n(1, 16'h8F0C, 4'b0110, 8'h8F, 1'b1, 1'b0);
      // Clear in the middle of a debounce and a read drops everything.
      add_n(3, 16'h0F0C, 4'b0000, 8'h8F, 1'b0, 1'b0);
      add(1'b1, 16'h0F0C, 4'b0100, 8'h00, 1'b0, 1'b0);
      add_n(6, 16'h0000, 4'b0000, 8'h00, 1'b0, 1'b0);
      add_n(1, 16'h0000, 4'b0100, 8'h00, 1'b1, 1'b0);
      add_n(1, 16'h0000, 4'b1000, 8'h00, 1'b1, 1'b0);
      // All pins high after reset flag every line after 2+DEB_CYCLES.
      add_n(5, 16'hFFFF, 4'b0000, 8'h00, 1'b0, 1'b0);
      add_n(1, 16'hFFFF, 4'b0000, 8'h00, 1'b0, 1'b1);
      add_n(1, 16'hFFFF, 4'b0001, 8'hFF, 1'b1, 1'b1);
      add_n(1, 16'hFFFF, 4'b0100, 8'hFF, 1'b1, 1'b1);
      add_n(1, 16'hFFFF, 4'b1000, 8'hFF, 1'b1, 1'b0);

      for (int k = 0; k < tbl.size(); k++) begin
         CLR    = tbl[k].clr;
         pin_in = tbl[k].pin;
         rd_sel = tbl[k].sel;
         tick();
         check("data_out", k, {8'h00, data_out}, {8'h00, tbl[k].d});
         check("rd_valid", k, {15'h0, rd_valid}, {15'h0, tbl[k].v});
         check("irq", k, {15'h0, irq}, {15'h0, tbl[k].i});
      end

      // Measured pin-to-irq latency on a fresh step of bit 4.
      CLR    = 1'b1;
      pin_in = 16'h0000;
      rd_sel = 4'b0000;
      tick();
      tick();
      CLR    = 1'b0;
      tick();
      pin_in = 16'h0010;
      n = 0;
      do begin
         tick();
         n++;
      end while (!irq && n < 20);
      check("irq_latency", 0, 16'(n), 16'd6);
      rd_sel = 4'b0001;
      tick();
      check("lvl_bit4", 0, {8'h00, data_out}, 16'h0010);
      rd_sel = 4'b0100;
      tick();
      check("chg_bit4", 0, {8'h00, data_out}, 16'h0010);
      check("irq_after_clr", 0, {15'h0, irq}, 16'h0000);
      rd_sel = 4'b0000;
      tick();
      check("valid_drop", 0, {15'h0, rd_valid}, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
